// File: rtl/rs422_frame_rx.sv
// rs422_frame_rx
// ---------------------------------------------------------------------------
// Frame receiver that sits behind a UART byte receiver. It hunts for a 0xAA
// header, then takes a LEN byte, LEN payload bytes and a CSUM byte. CSUM is
// the 8-bit wrapping sum of LEN and the payload. A good frame is held in a
// small buffer until the consumer has popped every byte with rd_en; while a
// frame is held, new bytes on the link are dropped.
//
// Optional feature macro: FRAME_TIMEOUT_EN
//   When defined, an inter-byte timeout of TIMEOUT_CYC clk cycles aborts a
//   partial frame with err_code 11. When undefined, no counter is built.
//
// Parameters
//   TIMEOUT_CYC  inter-byte timeout in clk cycles
//   MAX_LEN      largest accepted payload length (1..16)
//
// Ports
//   clk          byte-domain clock
//   rst          synchronous active-high reset
//   rx_data      received byte
//   rx_valid     one-cycle strobe qualifying rx_data
//   rd_en        pop one payload byte while a frame is held
//   rd_data      payload byte at the read pointer (combinational)
//   frame_ready  a checked frame is held in the buffer
//   frame_len    payload length of the held frame
//   frame_ok     one-cycle pulse, frame accepted
//   frame_err    one-cycle pulse, frame rejected
//   err_code     last error: 01 bad LEN, 10 checksum, 11 timeout
// ---------------------------------------------------------------------------
module rs422_frame_rx #(
    parameter int TIMEOUT_CYC = 1800,
    parameter int MAX_LEN     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       frame_ready,
    output logic [4:0] frame_len,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_LEN  = 3'd1,
        S_GET_PAY  = 3'd2,
        S_GET_CSUM = 3'd3,
        S_READY    = 3'd4
    } state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state;
    logic [7:0] pay_mem [0:15];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [4:0] len;
    logic [7:0] sum;
    logic       len_ok;
    logic       tmo_hit;

    assign len_ok  = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
    assign rd_data = pay_mem[rd_ptr];

`ifdef FRAME_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] tmo_cnt;
    logic          in_frame;

    assign in_frame = (state == S_GET_LEN) || (state == S_GET_PAY) ||
                      (state == S_GET_CSUM);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_hit  = in_frame && !rx_valid &&
                      (tmo_cnt == CW'(TIMEOUT_CYC - 1));

    // Inter-byte idle counter; only counts while a frame is being collected.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (in_frame && !rx_valid && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Payload buffer; deliberately not reset.
    always_ff @(posedge clk) begin
        if ((state == S_GET_PAY) && rx_valid) begin
            pay_mem[wr_ptr] <= rx_data;
        end
    end

    // Frame state machine with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= 4'd0;
            rd_ptr      <= 4'd0;
            len         <= 5'd0;
            sum         <= 8'd0;
            frame_ready <= 1'b0;
            frame_len   <= 5'd0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid && (rx_data == 8'hAA)) begin
                        state <= S_GET_LEN;
                    end
                end
                S_GET_LEN: begin
                    if (rx_valid) begin
                        if (len_ok) begin
                            len    <= rx_data[4:0];
                            sum    <= rx_data;
                            wr_ptr <= 4'd0;
                            state  <= S_GET_PAY;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b01;
                            state     <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b11;
                        state     <= S_IDLE;
                    end
                end
                S_GET_PAY: begin
                    if (rx_valid) begin
                        wr_ptr <= wr_ptr + 4'd1;
                        sum    <= sum + rx_data;
                        // len is 1..16, so len-1 always fits the 4-bit pointer.
                        if (wr_ptr == 4'(len - 5'd1)) begin
                            state <= S_GET_CSUM;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b11;
                        state     <= S_IDLE;
                    end
                end
                S_GET_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == sum) begin
                            frame_ok    <= 1'b1;
                            frame_ready <= 1'b1;
                            frame_len   <= len;
                            rd_ptr      <= 4'd0;
                            state       <= S_READY;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b10;
                            state     <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b11;
                        state     <= S_IDLE;
                    end
                end
                S_READY: begin
                    // Incoming bytes are dropped here; only the reader moves us on.
                    if (rd_en) begin
                        rd_ptr <= rd_ptr + 4'd1;
                        if (rd_ptr == 4'(frame_len - 5'd1)) begin
                            frame_ready <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs422_frame_rx.sv
// Self-checking bench for rs422_frame_rx. A queue-based frame model predicts
// the outputs every cycle; directed frames pin the model with literal values,
// then a long randomized byte stream exercises the general case.
module tb_rs422_frame_rx;

    localparam int TMO  = 20;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       frame_ready;
    logic [4:0] frame_len;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [7:0] cur[$];     // bytes of the frame being collected (starts with AA)
    logic [7:0] held[$];    // payload bytes still to be read
    int         idle;
    logic       exp_ok;
    logic       exp_err;
    logic [1:0] exp_code;
    logic [4:0] exp_len;

    always #5 clk = ~clk;

    rs422_frame_rx #(.TIMEOUT_CYC(TMO), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_en(rd_en), .rd_data(rd_data), .frame_ready(frame_ready),
        .frame_len(frame_len), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_code(err_code)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the outputs that follow one clock with the given inputs.
    task automatic model_update(input logic v, input logic [7:0] d, input logic r, input logic rs);
        int s;
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        if (rs) begin
            cur.delete();
            held.delete();
            idle     = 0;
            exp_code = 2'b00;
            exp_len  = 5'd0;
        end else if (held.size() > 0) begin
            if (r) void'(held.pop_front());
        end else if (v) begin
            idle = 0;
            if (cur.size() != 0 || d == 8'hAA) cur.push_back(d);
            if (cur.size() == 2 && (int'(cur[1]) == 0 || int'(cur[1]) > MAXL)) begin
                exp_err  = 1'b1;
                exp_code = 2'b01;
                cur.delete();
            end else if (cur.size() >= 3 && cur.size() == int'(cur[1]) + 3) begin
                s = 0;
                for (int i = 1; i < cur.size() - 1; i++) s += int'(cur[i]);
                if ((s % 256) == int'(cur[cur.size()-1])) begin
                    exp_ok  = 1'b1;
                    exp_len = cur[1][4:0];
                    for (int i = 2; i < cur.size() - 1; i++) held.push_back(cur[i]);
                end else begin
                    exp_err  = 1'b1;
                    exp_code = 2'b10;
                end
                cur.delete();
            end
        end else if (cur.size() != 0) begin
            idle++;
`ifdef FRAME_TIMEOUT_EN
            if (idle == TMO) begin
                exp_err  = 1'b1;
                exp_code = 2'b11;
                cur.delete();
            end
`endif
        end
    endtask

    task automatic check_outputs();
        chk("frame_ok", 32'(frame_ok), 32'(exp_ok));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        chk("err_code", 32'(err_code), 32'(exp_code));
        chk("frame_ready", 32'(frame_ready), 32'(held.size() > 0));
        if (held.size() > 0) begin
            chk("frame_len", 32'(frame_len), 32'(exp_len));
            chk("rd_data", 32'(rd_data), 32'(held[0]));
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic rs);
        rx_valid = v;
        rx_data  = d;
        rd_en    = r;
        rst      = rs;
        model_update(v, d, r, rs);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [7:0] q[$]);
        foreach (q[i]) step(1'b1, q[i], 1'b0, 1'b0);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 17 && held.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] fq[$];
        logic [7:0] rq[$];
        int         n;
        int         s;
        int         gap;

        idle = 0; exp_ok = 0; exp_err = 0; exp_code = 0; exp_len = 0;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rd_en = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_ready", 32'(frame_ready), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_len", 32'(frame_len), 32'd0);

        // Good frame with leading noise
        fq = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send(fq);
        chk("good_ok", 32'(frame_ok), 32'd1);
        chk("good_len", 32'(frame_len), 32'd3);
        chk("good_rd0", 32'(rd_data), 32'h11);
        chk("model_good_held", 32'(held.size()), 32'd3);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("good_rd1", 32'(rd_data), 32'h22);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("good_rd2", 32'(rd_data), 32'h33);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("good_fall", 32'(frame_ready), 32'd0);

        // Checksum error
        fq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
        send(fq);
        chk("csum_err", 32'(frame_err), 32'd1);
        chk("csum_code", 32'(err_code), 32'd2);
        chk("csum_ready", 32'(frame_ready), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("csum_pulse1", 32'(frame_err), 32'd0);

        // Bad LEN values, then a good frame
        fq = '{8'hAA, 8'h00};
        send(fq);
        chk("len0_code", 32'(err_code), 32'd1);
        chk("len0_err", 32'(frame_err), 32'd1);
        fq = '{8'hAA, 8'h11};
        send(fq);
        chk("len17_code", 32'(err_code), 32'd1);
        fq = '{8'hAA, 8'h01, 8'h40, 8'h41};
        send(fq);
        chk("after_bad_ok", 32'(frame_ok), 32'd1);
        drain();

        // Sum wrap
        fq = '{8'hAA, 8'h02, 8'hFF, 8'hFF, 8'h00};
        send(fq);
        chk("wrap_ok", 32'(frame_ok), 32'd1);
        chk("wrap_rd0", 32'(rd_data), 32'hFF);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_rd1", 32'(rd_data), 32'hFF);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Busy drop while a frame is held
        fq = '{8'hAA, 8'h01, 8'h07, 8'h08};
        send(fq);
        fq = '{8'hAA, 8'h01, 8'h05, 8'h06};
        send(fq);
        chk("busy_no_ok", 32'(frame_ok), 32'd0);
        chk("busy_rd", 32'(rd_data), 32'h07);
        chk("busy_code", 32'(err_code), 32'd1);
        drain();
        send(fq);
        chk("busy_after_ok", 32'(frame_ok), 32'd1);
        chk("busy_after_rd", 32'(rd_data), 32'h05);
        drain();

`ifdef FRAME_TIMEOUT_EN
        fq = '{8'hAA, 8'h02, 8'h11};
        send(fq);
        idle_n(TMO - 1);
        chk("tmo_early", 32'(frame_err), 32'd0);
        idle_n(1);
        chk("tmo_err", 32'(frame_err), 32'd1);
        chk("tmo_code", 32'(err_code), 32'd3);
        send(fq);
        idle_n(TMO - 1);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        chk("tmo_prio", 32'(frame_err), 32'd0);
        step(1'b1, 8'h35, 1'b0, 1'b0);
        chk("tmo_prio_ok", 32'(frame_ok), 32'd1);
        drain();
        send(fq);
        idle_n(5);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle_n(TMO + 5);
        chk("tmo_rst_err", 32'(frame_err), 32'd0);
        chk("tmo_rst_code", 32'(err_code), 32'd0);
        chk("tmo_rst_ready", 32'(frame_ready), 32'd0);
`else
        fq = '{8'hAA, 8'h02, 8'h11};
        send(fq);
        idle_n(TMO + 10);
        chk("notmo_err", 32'(frame_err), 32'd0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h35, 1'b0, 1'b0);
        chk("notmo_ok", 32'(frame_ok), 32'd1);
        drain();
`endif

        // Randomized byte stream with corrupt frames, gaps and resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (rq.size() == 0) begin
                for (int k = 0; k < $urandom_range(0, 2); k++) rq.push_back(8'($urandom));
                rq.push_back(8'hAA);
                case ($urandom_range(0, 9))
                    0:       n = 0;
                    1:       n = $urandom_range(17, 255);
                    default: n = $urandom_range(1, MAXL);
                endcase
                rq.push_back(8'(n));
                s = n;
                if (n >= 1 && n <= MAXL) begin
                    for (int k = 0; k < n; k++) begin
                        rq.push_back(8'($urandom));
                        s += int'(rq[rq.size()-1]);
                    end
                    if ($urandom_range(0, 4) == 0) rq.push_back(8'(s + 1));
                    else rq.push_back(8'(s));
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                step(1'b0, 8'($urandom), 1'b0, 1'b1);
            end else if ($urandom_range(0, 59) == 0) begin
                gap = $urandom_range(TMO - 2, TMO + 3);
                for (int k = 0; k < gap; k++)
                    step(1'b0, 8'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0);
            end else if ($urandom_range(0, 3) != 0) begin
                step(1'b1, rq.pop_front(), 1'($urandom_range(0, 2) == 0), 1'b0);
            end else begin
                step(1'b0, 8'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
